mem_access_stage: RTL
=====================

# mem_access_stage

MEM stage of the five-stage MIPS datapath. Consumes the EX/MEM pipeline register outputs and resolves branch and jump redirection. Performs the data-memory load or store over a ready/request handshake, stalling upstream until the access completes. Registers the result into the MEM/WB boundary and latches the first arithmetic, decode or memory exception.

## Interface
- TIMEOUT, 15: maximum cycles to wait for `dmem_ready` before raising a bus error (1..255).
- clk  in  1  stage clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous, active-low.
- in_valid  in  1  EX/MEM holds a real instruction; 0 means bubble.
- MEM_PC, PC_Branch, MEM_AluOut, MEM_ReadData2  in  32 each  PC, branch target, ALU result, store data.
- Jump_Addr  in  26  J-type target field.
- MEM_mux_RegDst_out  in  5  destination register.
- MEM_Branch, MEM_MemtoReg, MEM_MemWrite, MEM_RegWrite, MEM_Jump, MEM_zero, MEM_undefine, MEM_overflow  in  1 each  control and status flags.
- dmem_req  out  1  access request, registered.
- dmem_we  out  1  1 means store.
- dmem_addr, dmem_wdata  out  32 each  address and store data, registered.
- dmem_rdata  in  32  load data, valid with `dmem_ready`.
- dmem_ready  in  1  access complete.
- stall  out  1  freeze PC, IF/ID, ID/EX and EX/MEM.
- pc_redirect  out  1  take `pc_target` and flush the younger stages.
- pc_target  out  32  redirect address.
- WB_valid, WB_RegWrite, WB_MemtoReg  out  1 each  MEM/WB controls.
- WB_ReadData, WB_AluOut  out  32 each  load data and ALU result.
- WB_dest  out  5  destination register.
- exc_valid  out  1  sticky exception flag.
- exc_cause  out  3  exception cause: 1 undefined, 2 overflow, 3 misaligned, 4 bus timeout.
- exc_pc  out  32  PC of the faulting instruction.

## Operation
- FSM states: IDLE, ACCESS, EXC.
- IDLE with `in_valid`=0: `WB_valid`<=0; no other action.
- IDLE with `in_valid`=1 checks faults in priority order: `undefine` > `overflow` > misaligned.
- Misaligned means (`MemtoReg` | `MemWrite`) and `AluOut[1:0]`!=0.
- On any fault in IDLE:
  - Go to EXC; latch `exc_cause` and `exc_pc`=`MEM_PC`.
  - `WB_valid`<=0; no memory request is issued and no redirect is raised.
- IDLE, no fault, memory op:
  - Go to ACCESS.
  - Register `dmem_req`=1, `dmem_we`=`MemWrite`, `dmem_addr`=`AluOut`, `dmem_wdata`=`ReadData2`.
  - Capture `dest`, `RegWrite`, `MemtoReg` and `AluOut`; clear the wait counter.
- IDLE, no fault, no memory op: register the WB outputs directly with `WB_valid`<=1.
- ACCESS, `dmem_ready`=1:
  - `dmem_req`<=0.
  - `WB_ReadData`<=`dmem_rdata` on loads; on stores `WB_ReadData` is unchanged.
  - `WB_valid`<=1; return to IDLE.
- ACCESS, no ready, counter = TIMEOUT-1:
  - `dmem_req`<=0; go to EXC with cause 4 and `exc_pc` = captured PC.
- ACCESS otherwise: counter increments (8-bit).
- EXC: `stall`=1 and `exc_valid`=1; only reset exits this state.
- Redirect (combinational, IDLE only, `in_valid`=1, no fault):
  - `Jump` gives `pc_target` = {`MEM_PC[31:28]`, `Jump_Addr`, 2'b00}. Jump has priority over branch.
  - Else `Branch` & `zero` gives `pc_target` = `PC_Branch`.
  - Otherwise `pc_redirect`=0 and `pc_target`=0.
- `stall` = (state==ACCESS) | (state==EXC) | (IDLE and a memory op is being accepted this cycle).

## Timing
- Reset (`rst`=0 at a rising edge):
  - State returns to IDLE.
  - All registered outputs go to 0, including `exc_cause`, `exc_pc` and the counter.
  - Reset takes effect mid-ACCESS as well; the outstanding request is simply dropped.
- Non-memory instruction: reaches the WB outputs one cycle after acceptance.
- Load or store: minimum latency of 2 edges from acceptance; `dmem_req` is high from edge 1 until the edge that samples ready.
- The `dmem_*` outputs are held stable while `dmem_req`=1.
- A `dmem_ready` seen in IDLE or EXC is ignored.
- Ready arriving on the same edge as the counter reaching TIMEOUT-1 counts as success; ready takes priority.
- A redirect is asserted during the same cycle the instruction is presented, never while stalled.

## Test plan
- ALU op, `AluOut`=0x1234, `RegWrite`=1, dest=5 -> next edge: `WB_valid`=1, `WB_AluOut`=0x1234, `WB_dest`=5; `stall` never asserts.
- Load from 0x40, ready returned 3 cycles later with data 0xDEADBEEF -> `stall` high 4 cycles, `WB_ReadData`=0xDEADBEEF, `WB_MemtoReg`=1.
- Store to 0x42 -> `exc_cause`=3, `exc_pc`=`MEM_PC`, `dmem_req` stays 0; `stall` stays high until `rst`=0, then all outputs are 0.
- Jump with `MEM_PC`=0x80000010, `Jump_Addr`=0x0000100 -> `pc_redirect`=1, `pc_target`=0x80000400; with `Branch`=1, `zero`=1 as well, the jump still wins.
- Load with `dmem_ready` held low -> after 15 cycles `exc_cause`=4, `dmem_req`=0; `undefine` together with `overflow` on the same instruction gives cause 1.
- Assert `rst`=0 mid-ACCESS, then return ready -> state IDLE, `dmem_req`=0, ready ignored, `WB_valid`=0.

Source files
------------

// File: rtl/mem_access_stage.sv
// MEM stage of the five-stage MIPS pipeline: branch/jump redirect, data-memory
// access over a req/ready handshake, MEM/WB register and sticky exception capture.
module mem_access_stage #(
    parameter int TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [31:0] MEM_PC,
    input  logic [31:0] PC_Branch,
    input  logic [31:0] MEM_AluOut,
    input  logic [31:0] MEM_ReadData2,
    input  logic [25:0] Jump_Addr,
    input  logic [4:0]  MEM_mux_RegDst_out,
    input  logic        MEM_Branch,
    input  logic        MEM_MemtoReg,
    input  logic        MEM_MemWrite,
    input  logic        MEM_RegWrite,
    input  logic        MEM_Jump,
    input  logic        MEM_zero,
    input  logic        MEM_undefine,
    input  logic        MEM_overflow,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_ready,
    output logic        stall,
    output logic        pc_redirect,
    output logic [31:0] pc_target,
    output logic        WB_valid,
    output logic        WB_RegWrite,
    output logic        WB_MemtoReg,
    output logic [31:0] WB_ReadData,
    output logic [31:0] WB_AluOut,
    output logic [4:0]  WB_dest,
    output logic        exc_valid,
    output logic [2:0]  exc_cause,
    output logic [31:0] exc_pc,
    output logic [1:0]  dbg_state_o
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCESS = 2'd1;
    localparam logic [1:0] S_EXC    = 2'd2;

    // Handshake: dmem_req and the dmem_* payload are registered and held stable
    // while dmem_req=1; the access completes on the first rising edge that sees
    // dmem_ready=1 in ACCESS. Ready outside ACCESS is ignored.

    logic [1:0]  state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        req_q, req_d, we_q, we_d;
    logic [31:0] addr_q, addr_d, wdata_q, wdata_d;
    logic [31:0] cap_pc_q, cap_pc_d, cap_alu_q, cap_alu_d;
    logic [4:0]  cap_dest_q, cap_dest_d;
    logic        cap_rw_q, cap_rw_d, cap_mtr_q, cap_mtr_d;
    logic        wbv_q, wbv_d, wbrw_q, wbrw_d, wbmtr_q, wbmtr_d;
    logic [31:0] wbrd_q, wbrd_d, wbalu_q, wbalu_d;
    logic [4:0]  wbdest_q, wbdest_d;
    logic [2:0]  cause_q, cause_d;
    logic [31:0] epc_q, epc_d;

    logic        mem_op, misaligned, fault, take, accept_mem;
    logic [2:0]  fault_cause;

    always_comb begin
        mem_op     = MEM_MemtoReg | MEM_MemWrite;
        misaligned = mem_op & (MEM_AluOut[1:0] != 2'b00);
        if (MEM_undefine)      fault_cause = 3'd1;
        else if (MEM_overflow) fault_cause = 3'd2;
        else if (misaligned)   fault_cause = 3'd3;
        else                   fault_cause = 3'd0;
        fault      = (fault_cause != 3'd0);
        take       = (state_q == S_IDLE) & in_valid & ~fault;
        accept_mem = take & mem_op;
    end

    // Redirect only for an instruction leaving IDLE cleanly; jump beats branch.
    always_comb begin
        pc_redirect = 1'b0;
        pc_target   = 32'd0;
        if (take) begin
            if (MEM_Jump) begin
                pc_redirect = 1'b1;
                pc_target   = {MEM_PC[31:28], Jump_Addr, 2'b00};
            end else if (MEM_Branch & MEM_zero) begin
                pc_redirect = 1'b1;
                pc_target   = PC_Branch;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        req_d      = req_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        cap_pc_d   = cap_pc_q;
        cap_alu_d  = cap_alu_q;
        cap_dest_d = cap_dest_q;
        cap_rw_d   = cap_rw_q;
        cap_mtr_d  = cap_mtr_q;
        wbv_d      = wbv_q;
        wbrw_d     = wbrw_q;
        wbmtr_d    = wbmtr_q;
        wbrd_d     = wbrd_q;
        wbalu_d    = wbalu_q;
        wbdest_d   = wbdest_q;
        cause_d    = cause_q;
        epc_d      = epc_q;
        case (state_q)
            S_IDLE: begin
                wbv_d = 1'b0;
                if (in_valid && fault) begin
                    state_d = S_EXC;
                    cause_d = fault_cause;
                    epc_d   = MEM_PC;
                end else if (in_valid && mem_op) begin
                    state_d    = S_ACCESS;
                    req_d      = 1'b1;
                    we_d       = MEM_MemWrite;
                    addr_d     = MEM_AluOut;
                    wdata_d    = MEM_ReadData2;
                    cap_pc_d   = MEM_PC;
                    cap_alu_d  = MEM_AluOut;
                    cap_dest_d = MEM_mux_RegDst_out;
                    cap_rw_d   = MEM_RegWrite;
                    cap_mtr_d  = MEM_MemtoReg;
                    cnt_d      = 8'd0;
                end else if (in_valid) begin
                    wbv_d    = 1'b1;
                    wbrw_d   = MEM_RegWrite;
                    wbmtr_d  = MEM_MemtoReg;
                    wbalu_d  = MEM_AluOut;
                    wbdest_d = MEM_mux_RegDst_out;
                end
            end
            S_ACCESS: begin
                // Ready on the final wait cycle still counts as success.
                if (dmem_ready) begin
                    req_d    = 1'b0;
                    state_d  = S_IDLE;
                    wbv_d    = 1'b1;
                    wbrw_d   = cap_rw_q;
                    wbmtr_d  = cap_mtr_q;
                    wbalu_d  = cap_alu_q;
                    wbdest_d = cap_dest_q;
                    if (!we_q) wbrd_d = dmem_rdata;
                end else if (cnt_q == 8'(TIMEOUT - 1)) begin
                    req_d   = 1'b0;
                    state_d = S_EXC;
                    cause_d = 3'd4;
                    epc_d   = cap_pc_q;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_EXC:   state_d = S_EXC;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= 8'd0;
            req_q      <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= 32'd0;
            wdata_q    <= 32'd0;
            cap_pc_q   <= 32'd0;
            cap_alu_q  <= 32'd0;
            cap_dest_q <= 5'd0;
            cap_rw_q   <= 1'b0;
            cap_mtr_q  <= 1'b0;
            wbv_q      <= 1'b0;
            wbrw_q     <= 1'b0;
            wbmtr_q    <= 1'b0;
            wbrd_q     <= 32'd0;
            wbalu_q    <= 32'd0;
            wbdest_q   <= 5'd0;
            cause_q    <= 3'd0;
            epc_q      <= 32'd0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            req_q      <= req_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            cap_pc_q   <= cap_pc_d;
            cap_alu_q  <= cap_alu_d;
            cap_dest_q <= cap_dest_d;
            cap_rw_q   <= cap_rw_d;
            cap_mtr_q  <= cap_mtr_d;
            wbv_q      <= wbv_d;
            wbrw_q     <= wbrw_d;
            wbmtr_q    <= wbmtr_d;
            wbrd_q     <= wbrd_d;
            wbalu_q    <= wbalu_d;
            wbdest_q   <= wbdest_d;
            cause_q    <= cause_d;
            epc_q      <= epc_d;
        end
    end

    assign stall       = (state_q == S_ACCESS) | (state_q == S_EXC) | accept_mem;
    assign exc_valid   = (state_q == S_EXC);
    assign exc_cause   = cause_q;
    assign exc_pc      = epc_q;
    assign dmem_req    = req_q;
    assign dmem_we     = we_q;
    assign dmem_addr   = addr_q;
    assign dmem_wdata  = wdata_q;
    assign WB_valid    = wbv_q;
    assign WB_RegWrite = wbrw_q;
    assign WB_MemtoReg = wbmtr_q;
    assign WB_ReadData = wbrd_q;
    assign WB_AluOut   = wbalu_q;
    assign WB_dest     = wbdest_q;
    assign dbg_state_o = state_q;

endmodule
